// File: rtl/muldiv_seq_pkg.sv
// Shared MIPS decode constants for the HI/LO multiply/divide path.
// FUNCT_MFHI / FUNCT_MFLO are used by the hazard/stall logic, which holds
// those reads off while muldiv_seq reports busy.
package muldiv_seq_pkg;

   localparam logic [5:0] FUNCT_SLL   = 6'h00;
   localparam logic [5:0] FUNCT_JR    = 6'h08;
   localparam logic [5:0] FUNCT_MFHI  = 6'h10;
   localparam logic [5:0] FUNCT_MTHI  = 6'h11;
   localparam logic [5:0] FUNCT_MFLO  = 6'h12;
   localparam logic [5:0] FUNCT_MTLO  = 6'h13;
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
   localparam logic [5:0] FUNCT_ADDU  = 6'h21;

   // Signed variants take operand magnitudes and apply a sign fix-up at the end.
   function automatic logic funct_is_signed(input logic [5:0] f);
      return (f == FUNCT_MULT) || (f == FUNCT_DIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multi-cycle mul/div datapath.
//   mode_div = 0 : shift-add multiply. {acc_hi,acc_lo} is the 2*WIDTH
//                  accumulator with the multiplier in acc_lo; operand is the
//                  multiplicand.
//   mode_div = 1 : restoring shift-subtract divide. acc_hi is the partial
//                  remainder, acc_lo the dividend shifting into the quotient;
//                  operand is the divisor.
// Ports: mode_div, acc_hi, acc_lo, operand in; nxt_hi, nxt_lo out.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             mode_div,
   input  logic [WIDTH-1:0] acc_hi,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] nxt_hi,
   output logic [WIDTH-1:0] nxt_lo
);

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_diff;
   logic             div_ge;

   // Add (or not) into the upper half with a carry bit, then shift the whole
   // accumulator right by one; the carry lands in the top of the product.
   assign mul_sum = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, operand}) : {1'b0, acc_hi};

   // Remainder shifted left with the next dividend bit is WIDTH+1 bits wide.
   // When it is >= divisor the difference always fits in WIDTH bits.
   assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
   assign div_ge    = (div_shift >= {1'b0, operand});
   assign div_diff  = div_shift[WIDTH-1:0] - operand;

   always_comb begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
      if (mode_div) begin
         nxt_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
         nxt_lo = {acc_lo[WIDTH-2:0], div_ge};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// HI/LO multiply/divide sequencer for the execute stage.
// Accepts MULT/MULTU/DIV/DIVU (32 step cycles + one fix-up cycle) and
// MTHI/MTLO (single cycle, no busy). HI/LO only change on MTHI/MTLO or at the
// end of the fix-up cycle, so they never expose partial results.
// Ports: clk, rst_n, start, fncode[5:0], op_a, op_b in; busy, hi, lo out.
//
// state  | meaning
// IDLE   | waiting for start; MTHI/MTLO handled here
// MUL    | one shift-add step per cycle
// DIV    | one restoring shift-subtract step per cycle
// FIX    | sign fix-up and HI/LO write
module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [5:0]       fncode,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
   logic              div_q, div_d;
   logic              busy_q, busy_d;
   logic [WIDTH-1:0]  opnd_q, opnd_d;
   logic [WIDTH-1:0]  acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;

   logic              sgn_op, neg_a, neg_b;
   logic [WIDTH-1:0]  abs_a, abs_b;
   logic [WIDTH-1:0]  step_hi, step_lo;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]  quot_fix, rem_fix;

   // Negating INT_MIN yields 0x80000000, which is the correct unsigned magnitude.
   assign sgn_op = funct_is_signed(fncode);
   assign neg_a  = sgn_op & op_a[WIDTH-1];
   assign neg_b  = sgn_op & op_b[WIDTH-1];
   assign abs_a  = neg_a ? (~op_a + 1'b1) : op_a;
   assign abs_b  = neg_b ? (~op_b + 1'b1) : op_b;

   assign prod_fix = (sign_a_q ^ sign_b_q) ? (~{acc_hi_q, acc_lo_q} + 1'b1)
                                           : {acc_hi_q, acc_lo_q};
   assign quot_fix = (sign_a_q ^ sign_b_q) ? (~acc_lo_q + 1'b1) : acc_lo_q;
   assign rem_fix  = sign_a_q ? (~acc_hi_q + 1'b1) : acc_hi_q;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .mode_div (state_q == S_DIV),
      .acc_hi   (acc_hi_q),
      .acc_lo   (acc_lo_q),
      .operand  (opnd_q),
      .nxt_hi   (step_hi),
      .nxt_lo   (step_lo)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      div_d    = div_q;
      opnd_d   = opnd_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (fncode)
                  FUNCT_MTHI: hi_d = op_a;
                  FUNCT_MTLO: lo_d = op_a;
                  FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
                     sign_a_d = neg_a;
                     sign_b_d = neg_b;
                     cnt_d    = '0;
                     acc_hi_d = '0;
                     div_d    = (fncode == FUNCT_DIV) || (fncode == FUNCT_DIVU);
                     if (div_d) begin
                        acc_lo_d = abs_a;
                        opnd_d   = abs_b;
                        state_d  = S_DIV;
                     end else begin
                        acc_lo_d = abs_b;
                        opnd_d   = abs_a;
                        state_d  = S_MUL;
                     end
                  end
                  default: ;
               endcase
            end
         end
         S_MUL, S_DIV: begin
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) state_d = S_FIX;
         end
         S_FIX: begin
            if (div_q) begin
               lo_d = quot_fix;
               hi_d = rem_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         div_q    <= 1'b0;
         busy_q   <= 1'b0;
         opnd_q   <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         div_q    <= div_d;
         busy_q   <= busy_d;
         opnd_q   <= opnd_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
